// File: rtl/core3_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory stage.
// Build option: OCIMEM_PARITY_EN widens the debug RAM to 33 bits with even parity.
package core3_ocimem_pkg;

  typedef enum logic [1:0] {J_IDLE, J_RD, J_CAP} jfsm_t;
  typedef enum logic [1:0] {C_IDLE, C_ACC, C_DONE} cfsm_t;

  localparam int JDO_RD     = 35;
  localparam int JDO_CLRERR = 34;
  localparam int JDO_WD_HI  = 34;
  localparam int JDO_WD_LO  = 3;
  localparam int JDO_A_LO   = 2;

`ifdef OCIMEM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  // Stored word: data plus, when enabled, a bit that makes the total parity even.
  function automatic logic [RAM_W-1:0] ram_pack(input logic [31:0] d);
`ifdef OCIMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic logic ram_parity_bad(input logic [RAM_W-1:0] w);
`ifdef OCIMEM_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/core3_ocimem_ram.sv
// Single-port synchronous debug RAM with a registered read (1-cycle latency).
// Width comes from the package and depends on OCIMEM_PARITY_EN; contents are never reset.
module core3_ocimem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/core3_cpu_1_jtag_ocimem.sv
// OCI debug-memory stage: JTAG command decode plus a wait-stated CPU port sharing one RAM.
// Build option: OCIMEM_PARITY_EN adds stored parity and parity-fault reporting.
module core3_cpu_1_jtag_ocimem
  import core3_ocimem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  jfsm_t j_state_reg, j_state_next;
  cfsm_t c_state_reg, c_state_next;
  logic [AW-1:0] mon_a_reg, mon_a_next;
  logic [31:0]   mon_d_reg;
  logic          ready_reg;
  logic          err_reg, err_next;
  logic          c_rd_reg;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_q;

  logic j_idle, do_a, do_na, do_b, addr_bad, start_rd, jtag_port, cpu_grant, par_bad;
  logic unused_jdo;

  // Pulses only count in J_IDLE; ocimem_a outranks the other two.
  assign j_idle    = (j_state_reg == J_IDLE);
  assign do_a      = j_idle & take_action_ocimem_a;
  assign do_na     = j_idle & take_no_action_ocimem_a & ~take_action_ocimem_a;
  assign do_b      = j_idle & take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
  assign addr_bad  = |(jdo[17:0] >> (AW + JDO_A_LO));
  assign start_rd  = (do_a & ~addr_bad & jdo[JDO_RD]) | do_na;
  assign jtag_port = do_b | (j_state_reg == J_RD);
  assign cpu_grant = (c_state_reg == C_ACC) & ~jtag_port;
  assign par_bad   = ram_parity_bad(ram_q);
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  always_comb begin
    j_state_next = j_state_reg;
    unique case (j_state_reg)
      J_IDLE:  if (start_rd) j_state_next = J_RD;
      J_RD:    j_state_next = J_CAP;
      J_CAP:   j_state_next = J_IDLE;
      default: j_state_next = J_IDLE;
    endcase
  end

  always_comb begin
    c_state_next = c_state_reg;
    unique case (c_state_reg)
      C_IDLE:  if (avs_read | avs_write) c_state_next = C_ACC;
      C_ACC:   if (cpu_grant) c_state_next = C_DONE;
      C_DONE:  c_state_next = C_IDLE;
      default: c_state_next = C_IDLE;
    endcase
  end

  always_comb begin
    mon_a_next = mon_a_reg;
    if (do_a) mon_a_next = jdo[AW+JDO_A_LO-1:JDO_A_LO];
    else if (do_na | do_b) mon_a_next = mon_a_reg + 1'b1;
  end

  // Clear is applied before the range check, so a bad address with clear still errors.
  always_comb begin
    err_next = err_reg;
    if (do_a && jdo[JDO_CLRERR]) err_next = 1'b0;
    if (do_a && addr_bad) err_next = 1'b1;
    if (j_state_reg == J_CAP && par_bad) err_next = 1'b1;
    if (c_state_reg == C_DONE && c_rd_reg && par_bad) err_next = 1'b1;
  end

  // RAM port: JTAG write, then JTAG read, then the CPU.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mon_a_reg;
    ram_wdata = ram_pack(avs_writedata);
    if (do_b) begin
      ram_we    = reset_n;
      ram_wdata = ram_pack(jdo[JDO_WD_HI:JDO_WD_LO]);
    end else if (j_state_reg == J_RD) begin
      ram_addr = mon_a_reg;
    end else if (cpu_grant) begin
      ram_addr = avs_address;
      ram_we   = avs_write & reset_n;
    end
  end

  core3_ocimem_ram #(.DEPTH(DEPTH), .AW(AW), .W(RAM_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j_state_reg <= J_IDLE;
      c_state_reg <= C_IDLE;
      mon_a_reg   <= '0;
      mon_d_reg   <= '0;
      ready_reg   <= 1'b1;
      err_reg     <= 1'b0;
      c_rd_reg    <= 1'b0;
    end else begin
      j_state_reg <= j_state_next;
      c_state_reg <= c_state_next;
      mon_a_reg   <= mon_a_next;
      err_reg     <= err_next;
      if (start_rd) ready_reg <= 1'b0;
      else if (j_state_reg == J_CAP) ready_reg <= 1'b1;
      if (j_state_reg == J_CAP) mon_d_reg <= ram_q[31:0];
      if (cpu_grant) c_rd_reg <= avs_read;
    end
  end

  assign MonDReg         = mon_d_reg;
  assign monitor_ready   = ready_reg;
  assign monitor_error   = err_reg;
  assign avs_waitrequest = (c_state_reg != C_DONE);
  assign avs_readdata    = (c_state_reg == C_DONE && c_rd_reg) ? ram_q[31:0] : 32'h0;

endmodule

// File: tb/tb_core3_cpu_1_jtag_ocimem.sv
// Randomized self-checking bench for core3_cpu_1_jtag_ocimem against an array-based memory model.
// The parity scenario is compiled in only when OCIMEM_PARITY_EN is defined.
module tb_core3_cpu_1_jtag_ocimem;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          take_a, take_na, take_b;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [31:0]   mon_d;
  logic          mon_ready, mon_error;

  int checks = 0;
  int failures = 0;

  // Reference model: memory contents, JTAG address pointer, last JTAG read data.
  logic [31:0] model_mem [DEPTH];
  int          model_a;
  logic [31:0] model_d;

  core3_cpu_1_jtag_ocimem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error)
  );

  always #5 clk = ~clk;

  // ---- stimulus drivers (no checking inside) ----
  task automatic pulse_a(input int field, input logic rd, input logic clr);
    @(negedge clk);
    jdo = '0; jdo[35] = rd; jdo[34] = clr; jdo[17:2] = field[15:0]; take_a = 1'b1;
    @(negedge clk);
    take_a = 1'b0; jdo = '0;
  endtask

  task automatic pulse_na();
    @(negedge clk); take_na = 1'b1;
    @(negedge clk); take_na = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    @(negedge clk); jdo = '0; jdo[34:3] = d; take_b = 1'b1;
    @(negedge clk); take_b = 1'b0; jdo = '0;
  endtask

  // Counts the negedges with ready low, starting at the negedge right after the pulse.
  task automatic wait_ready(output int lows);
    lows = 0;
    while (mon_ready !== 1'b1 && lows < 10) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic cpu_rd(input int addr, output logic [31:0] d, output int cyc);
    @(negedge clk);
    avs_address = addr[AW-1:0]; avs_read = 1'b1; cyc = 0;
    do begin @(negedge clk); cyc++; end while (avs_waitrequest !== 1'b0 && cyc < 10);
    d = avs_readdata; avs_read = 1'b0;
  endtask

  task automatic cpu_wr(input int addr, input logic [31:0] d, output int cyc);
    @(negedge clk);
    avs_address = addr[AW-1:0]; avs_writedata = d; avs_write = 1'b1; cyc = 0;
    do begin @(negedge clk); cyc++; end while (avs_waitrequest !== 1'b0 && cyc < 10);
    avs_write = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mon_d !== 32'h0 || mon_ready !== 1'b1 || mon_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mon: got d=%h rdy=%b err=%b want d=0 rdy=1 err=0", mon_d, mon_ready, mon_error);
    end
    checks++;
    if (avs_waitrequest !== 1'b1 || avs_readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_avs: got wait=%b rd=%h want wait=1 rd=0", avs_waitrequest, avs_readdata);
    end
    reset_n = 1'b1;
    model_a = 0; model_d = 0;
    @(negedge clk);
    $display("reset released: MonDReg=%h ready=%b", mon_d, mon_ready);
  endtask

  task automatic test_fill();
    int lows;
    pulse_a(0, 1'b0, 1'b0);
    model_a = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom;
      pulse_b(d);
      model_mem[model_a] = d;
      model_a = (model_a + 1) % DEPTH;
    end
    pulse_na();
    model_a = (model_a + 1) % DEPTH;
    wait_ready(lows);
    checks++;
    if (lows !== 2 || mon_d !== model_mem[model_a]) begin
      failures++;
      $display("FAIL fill_stream: got lows=%0d d=%h want lows=2 d=%h", lows, mon_d, model_mem[model_a]);
    end
    $display("fill: %0d words streamed, readback addr %0d = %h", DEPTH, model_a, mon_d);
  endtask

  task automatic test_read_addr5();
    int cyc, lows;
    cpu_wr(5, 32'hDEADBEEF, cyc);
    model_mem[5] = 32'hDEADBEEF;
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL cpu_wr_latency: got %0d want 2", cyc);
    end
    pulse_a(5, 1'b1, 1'b0);
    model_a = 5;
    wait_ready(lows);
    checks++;
    if (lows !== 2 || mon_d !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_addr5: got lows=%0d d=%h want lows=2 d=deadbeef", lows, mon_d);
    end
    $display("jtag read addr 5: MonDReg=%h ready-low=%0d clk", mon_d, lows);
  endtask

  task automatic test_wrap();
    int lows;
    pulse_a(DEPTH - 1, 1'b0, 1'b0);
    model_a = DEPTH - 1;
    checks++;
    if (mon_ready !== 1'b1) begin
      failures++;
      $display("FAIL addr_only_ready: got %b want 1", mon_ready);
    end
    pulse_b(32'h12345678);
    model_mem[DEPTH-1] = 32'h12345678;
    model_a = 0;
    pulse_na();
    model_a = 1;
    wait_ready(lows);
    checks++;
    if (mon_d !== model_mem[1]) begin
      failures++;
      $display("FAIL wrap_after_write: got %h want %h", mon_d, model_mem[1]);
    end
    pulse_a(DEPTH - 1, 1'b0, 1'b0);
    pulse_na();
    model_a = 0;
    wait_ready(lows);
    checks++;
    if (mon_d !== model_mem[0]) begin
      failures++;
      $display("FAIL wrap_na: got %h want %h", mon_d, model_mem[0]);
    end
    pulse_a(DEPTH - 1, 1'b1, 1'b0);
    model_a = DEPTH - 1;
    wait_ready(lows);
    checks++;
    if (mon_d !== 32'h12345678) begin
      failures++;
      $display("FAIL top_word: got %h want 12345678", mon_d);
    end
    $display("wrap: RAM[%0d]=%h", DEPTH - 1, mon_d);
  endtask

  task automatic test_range_error();
    int lows;
    logic [31:0] prev;
    prev = mon_d;
    pulse_a(DEPTH, 1'b1, 1'b0);
    model_a = 0;
    checks++;
    if (mon_error !== 1'b1 || mon_ready !== 1'b1) begin
      failures++;
      $display("FAIL range_err: got err=%b rdy=%b want err=1 rdy=1", mon_error, mon_ready);
    end
    wait_ready(lows);
    checks++;
    if (lows !== 0 || mon_d !== prev) begin
      failures++;
      $display("FAIL range_noaccess: got lows=%0d d=%h want lows=0 d=%h", lows, mon_d, prev);
    end
    pulse_a(DEPTH + 3, 1'b0, 1'b1);
    model_a = 3;
    checks++;
    if (mon_error !== 1'b1) begin
      failures++;
      $display("FAIL clr_with_bad: got %b want 1", mon_error);
    end
    pulse_a(7, 1'b1, 1'b1);
    model_a = 7;
    checks++;
    if (mon_error !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: got %b want 0", mon_error);
    end
    wait_ready(lows);
    checks++;
    if (lows !== 2 || mon_d !== model_mem[7]) begin
      failures++;
      $display("FAIL clr_read: got lows=%0d d=%h want lows=2 d=%h", lows, mon_d, model_mem[7]);
    end
    $display("range: error set then cleared, addr 7 = %h", mon_d);
  endtask

  task automatic test_collision();
    int x, cyc;
    logic [31:0] d;
    x = $urandom_range(0, DEPTH - 1);
    d = $urandom;
    pulse_a(x, 1'b0, 1'b0);
    model_a = x;
    @(negedge clk);
    avs_address = x[AW-1:0]; avs_read = 1'b1; cyc = 0;
    @(negedge clk); cyc++;
    jdo = '0; jdo[34:3] = d; take_b = 1'b1;
    @(negedge clk); cyc++;
    take_b = 1'b0; jdo = '0;
    while (avs_waitrequest !== 1'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    model_mem[x] = d;
    model_a = (x + 1) % DEPTH;
    checks++;
    if (cyc !== 3 || avs_readdata !== d) begin
      failures++;
      $display("FAIL collision: got cyc=%0d rd=%h want cyc=3 rd=%h", cyc, avs_readdata, d);
    end
    avs_read = 1'b0;
    $display("collision at %0d: cpu read %h after %0d clk", x, avs_readdata, cyc);
  endtask

  task automatic test_busy_ignore();
    int y, lows;
    y = $urandom_range(0, DEPTH - 2);
    @(negedge clk);
    jdo = '0; jdo[35] = 1'b1; jdo[17:2] = y[15:0]; take_a = 1'b1;
    @(negedge clk);
    take_a = 1'b0; jdo = '0; jdo[34:3] = ~model_mem[y]; take_b = 1'b1;
    @(negedge clk);
    take_b = 1'b0; jdo = '0; take_na = 1'b1;
    checks++;
    if (mon_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready_low: got %b want 0", mon_ready);
    end
    @(negedge clk);
    take_na = 1'b0;
    model_a = y;
    checks++;
    if (mon_ready !== 1'b1 || mon_d !== model_mem[y]) begin
      failures++;
      $display("FAIL busy_read: got rdy=%b d=%h want rdy=1 d=%h", mon_ready, mon_d, model_mem[y]);
    end
    pulse_na();
    model_a = y + 1;
    wait_ready(lows);
    checks++;
    if (mon_d !== model_mem[y+1]) begin
      failures++;
      $display("FAIL busy_ignored: got %h want %h", mon_d, model_mem[y+1]);
    end
    $display("busy: pulses during read ignored, addr %0d = %h", y + 1, mon_d);
  endtask

  task automatic test_random();
    int op, addr, cyc, lows;
    logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      addr = $urandom_range(0, DEPTH - 1);
      d = $urandom;
      case (op)
        0: begin
          pulse_a(addr, 1'b0, 1'b0);
          pulse_b(d);
          model_mem[addr] = d;
          model_a = (addr + 1) % DEPTH;
          $display("rand %0d: jtag write [%0d]=%h", i, addr, d);
        end
        1: begin
          pulse_a(addr, 1'b1, 1'b0);
          model_a = addr;
          wait_ready(lows);
          checks++;
          if (lows !== 2 || mon_d !== model_mem[addr]) begin
            failures++;
            $display("FAIL rand_jtag_rd: [%0d] got lows=%0d d=%h want lows=2 d=%h", addr, lows, mon_d, model_mem[addr]);
          end
          $display("rand %0d: jtag read [%0d]=%h", i, addr, mon_d);
        end
        2: begin
          cpu_wr(addr, d, cyc);
          model_mem[addr] = d;
          $display("rand %0d: cpu write [%0d]=%h", i, addr, d);
        end
        default: begin
          cpu_rd(addr, d, cyc);
          checks++;
          if (cyc !== 2 || d !== model_mem[addr]) begin
            failures++;
            $display("FAIL rand_cpu_rd: [%0d] got cyc=%0d d=%h want cyc=2 d=%h", addr, cyc, d, model_mem[addr]);
          end
          $display("rand %0d: cpu read [%0d]=%h", i, addr, d);
        end
      endcase
    end
  endtask

  task automatic test_reset_abort();
    int lows;
    logic [31:0] old0;
    old0 = model_mem[0];
    pulse_a(DEPTH * 2, 1'b0, 1'b0);
    pulse_a(9, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mon_d !== 32'h0 || mon_ready !== 1'b1 || mon_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: got d=%h rdy=%b err=%b want d=0 rdy=1 err=0", mon_d, mon_ready, mon_error);
    end
    @(negedge clk);
    jdo = '0; jdo[34:3] = ~old0; take_b = 1'b1;
    @(negedge clk);
    take_b = 1'b0; jdo = '0; reset_n = 1'b1;
    model_a = 0; model_d = 0;
    pulse_a(0, 1'b1, 1'b0);
    wait_ready(lows);
    checks++;
    if (mon_d !== old0) begin
      failures++;
      $display("FAIL reset_no_write: got %h want %h", mon_d, old0);
    end
    $display("reset abort: RAM[0]=%h unchanged", mon_d);
  endtask

`ifdef OCIMEM_PARITY_EN
  task automatic test_parity();
    int a, lows;
    a = $urandom_range(0, DEPTH - 1);
    pulse_a(a, 1'b1, 1'b1);
    wait_ready(lows);
    checks++;
    if (mon_error !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean: got err=%b want 0", mon_error);
    end
    dut.u_ram.mem[a] = dut.u_ram.mem[a] ^ 33'h1_0000_0000;
    pulse_a(a, 1'b1, 1'b0);
    wait_ready(lows);
    checks++;
    if (mon_error !== 1'b1 || mon_d !== model_mem[a]) begin
      failures++;
      $display("FAIL parity_err: got err=%b d=%h want err=1 d=%h", mon_error, mon_d, model_mem[a]);
    end
    $display("parity: flipped [%0d], err=%b d=%h", a, mon_error, mon_d);
  endtask
`endif

  initial begin
    jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    test_reset();
    test_fill();
    test_read_addr5();
    test_wrap();
    test_range_error();
    test_collision();
    test_busy_ignore();
    test_random();
    test_reset_abort();
`ifdef OCIMEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
